// File: rtl/pwm_pkg.sv
// pwm_pkg: shared types and constants for the PWM scheduler slice.
//   state_e   : scheduler FSM states (IDLE, RUN)
//   NUM_CH    : number of output channels
//   DUTY_W    : duty cycle width
//   DUTY_OFF  : duty code that forces the PWM level low
//   DUTY_FULL : duty code that forces the PWM level high
package pwm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam int NUM_CH = 16;
  localparam int DUTY_W = 8;

  localparam logic [DUTY_W-1:0] DUTY_OFF  = 8'h00;
  localparam logic [DUTY_W-1:0] DUTY_FULL = 8'hFF;

endpackage

// File: rtl/pwm_scheduler_prescaler.sv
// pwm_prescaler: reusable clock-enable generator.
// Counts 0..DIV-1 while enabled and pulses tick_o on the terminal count,
// then wraps to 0. A synchronous clear holds the count at 0.
// Ports:
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   en_i   : count enable
//   clr_i  : synchronous clear (dominates en_i)
//   tick_o : high for one cycle when the count is at DIV-1 and enabled
module pwm_prescaler #(
  parameter int DIV = 10,
  parameter int W   = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam logic [W-1:0] TC = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == TC) ? '0 : cnt_q + 1'b1;
    end
  end

  assign tick_o = en_i && !clr_i && (cnt_q == TC);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pwm_scheduler.sv
// pwm_scheduler: drives 16 output pins from register-bank configuration.
// A prescaled CNT_W-bit period counter generates the PWM waveform. The
// PWM select and duty are shadowed and only reload at a period boundary,
// so a write never truncates or glitches a pulse. en_out is live.
// Optional build macro: PWM_RAMP_EN -- shadow duty steps by 1 per boundary
// toward the target and a ramp_done output is added.
// Ports:
//   clk          : system clock
//   rst_n        : asynchronous active-low reset
//   en_out       : per-channel output enable (live)
//   en_pwm       : per-channel PWM select (shadowed)
//   duty         : target duty cycle (shadowed)
//   cfg_valid    : one-cycle pulse when the register bank commits a write
//   pwm_out      : registered channel outputs
//   period_start : one-cycle pulse when the counter restarts at 0
//   busy         : high while in RUN
//   ramp_done    : (PWM_RAMP_EN only) shadow duty equals target
module pwm_scheduler
  import pwm_pkg::*;
#(
  parameter int CLK_DIV = 10,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] en_out,
  input  logic [NUM_CH-1:0] en_pwm,
  input  logic [DUTY_W-1:0] duty,
  input  logic              cfg_valid,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              period_start,
  output logic              busy
`ifdef PWM_RAMP_EN
  ,
  output logic              ramp_done
`endif
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam int CMP_W = (CNT_W > DUTY_W) ? CNT_W : DUTY_W;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_CH-1:0]  en_sh_q, en_sh_d;
  logic [DUTY_W-1:0]  duty_sh_q, duty_sh_d;
  logic               pending_q, pending_d;
  logic [NUM_CH-1:0]  pwm_q, pwm_d;
  logic               pstart_q, pstart_d;
`ifdef PWM_RAMP_EN
  logic [DUTY_W-1:0]  tgt_q, tgt_d;
`endif

  logic tick;
  logic boundary;
  logic load;
  logic level;
  logic [CMP_W-1:0] cnt_ext;
  logic [CMP_W-1:0] duty_ext;

  // Prescaler runs only in RUN; it is held clear in IDLE so RUN entry
  // always starts a full first tick.
  pwm_prescaler #(
    .DIV (CLK_DIV),
    .W   (16)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .en_i   (state_q == RUN),
    .clr_i  (state_q != RUN),
    .tick_o (tick)
  );

  assign boundary = tick && (cnt_q == CNT_MAX);

  assign cnt_ext  = CMP_W'(cnt_q);
  assign duty_ext = CMP_W'(duty_sh_q);

  always_comb begin
    if (duty_sh_q == DUTY_OFF) begin
      level = 1'b0;
    end else if (duty_sh_q == DUTY_FULL) begin
      level = 1'b1;
    end else begin
      level = (cnt_ext < duty_ext);
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    en_sh_d   = en_sh_q;
    duty_sh_d = duty_sh_q;
    pending_d = pending_q | cfg_valid;
    pstart_d  = 1'b0;
    load      = 1'b0;
`ifdef PWM_RAMP_EN
    tgt_d     = cfg_valid ? duty : tgt_q;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (cfg_valid && (en_pwm != '0)) begin
          load     = 1'b1;
          state_d  = RUN;
          pstart_d = 1'b1;
        end
      end
      RUN: begin
        if (tick) begin
          cnt_d = cnt_q + 1'b1;
        end
        pstart_d = boundary;
        // A write landing on the boundary cycle is taken directly from the
        // inputs, so it applies to the period that starts right now.
        if (boundary && (pending_q || cfg_valid)) begin
          load = 1'b1;
          if (en_pwm == '0) begin
            state_d  = IDLE;
            cnt_d    = '0;
            pstart_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      en_sh_d   = en_pwm;
      pending_d = 1'b0;
`ifdef PWM_RAMP_EN
      // A fresh start has no pulse in flight, so the target loads directly.
      if (state_q == IDLE) begin
        duty_sh_d = tgt_d;
      end else if (duty_sh_q < tgt_d) begin
        duty_sh_d = duty_sh_q + 1'b1;
      end else if (duty_sh_q > tgt_d) begin
        duty_sh_d = duty_sh_q - 1'b1;
      end
      pending_d = (duty_sh_d != tgt_d);
`else
      duty_sh_d = duty;
`endif
    end
  end

  // Channels without PWM select pass en_out straight through as a static level.
  assign pwm_d = en_out & (~en_sh_q | {NUM_CH{level}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      en_sh_q   <= '0;
      duty_sh_q <= '0;
      pending_q <= 1'b0;
      pwm_q     <= '0;
      pstart_q  <= 1'b0;
`ifdef PWM_RAMP_EN
      tgt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      en_sh_q   <= en_sh_d;
      duty_sh_q <= duty_sh_d;
      pending_q <= pending_d;
      pwm_q     <= pwm_d;
      pstart_q  <= pstart_d;
`ifdef PWM_RAMP_EN
      tgt_q     <= tgt_d;
`endif
    end
  end

  assign pwm_out      = pwm_q;
  assign period_start = pstart_q;
  assign busy         = (state_q == RUN);
`ifdef PWM_RAMP_EN
  assign ramp_done    = (duty_sh_q == tgt_q);
`endif

endmodule

// File: tb/tb_pwm_scheduler.sv
// tb_pwm_scheduler: directed self-checking bench for pwm_scheduler
// (CLK_DIV=10, CNT_W=8, so one PWM period is 2560 clk cycles).
module tb_pwm_scheduler;

  logic        clk;
  logic        rst_n;
  logic [15:0] en_out;
  logic [15:0] en_pwm;
  logic [7:0]  duty;
  logic        cfg_valid;
  logic [15:0] pwm_out;
  logic        period_start;
  logic        busy;
`ifdef PWM_RAMP_EN
  logic        ramp_done;
`endif

  int checks;
  int failures;

  pwm_scheduler #(
    .CLK_DIV (10),
    .CNT_W   (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en_out       (en_out),
    .en_pwm       (en_pwm),
    .duty         (duty),
    .cfg_valid    (cfg_valid),
    .pwm_out      (pwm_out),
    .period_start (period_start),
    .busy         (busy)
`ifdef PWM_RAMP_EN
    ,
    .ramp_done    (ramp_done)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en_out    = '0;
    en_pwm    = '0;
    duty      = '0;
    cfg_valid = 1'b0;
    rst_n     = 1'b0;
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  // Drive a one-cycle cfg_valid; returns at the sample just after the edge.
  task automatic pulse_cfg();
    cfg_valid = 1'b1;
    step();
    cfg_valid = 1'b0;
  endtask

  // Waits (bounded) for a period_start sample, then observes the next 2560
  // samples of pwm_out[0]. Optionally issues a write after sample wr_at.
  task automatic measure(input int wr_at, input logic [7:0] wr_duty,
                         output int hi, output int first, output int last,
                         output int ps_at, output bit tmo);
    int n;
    hi = 0; first = 0; last = 0; ps_at = 0; n = 0;
    while (!period_start && n < 3000) begin
      step();
      n++;
    end
    tmo = !period_start;
    for (int s = 1; s <= 2560; s++) begin
      step();
      if (pwm_out[0]) begin
        hi++;
        if (first == 0) first = s;
        last = s;
      end
      if (period_start && ps_at == 0) ps_at = s;
      if (wr_at != 0 && s == wr_at) begin
        duty      = wr_duty;
        cfg_valid = 1'b1;
      end
      if (wr_at != 0 && s == wr_at + 1) cfg_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    en_out = 16'hFFFF;
    en_pwm = 16'h0000;
    duty   = 8'h80;
    cfg_valid = 1'b0;
    step();
    step();
    checks++;
    if (pwm_out !== 16'h0000) begin failures++; $display("FAIL reset_pwm_out got=%h exp=%h", pwm_out, 16'h0000); end
    checks++;
    if (busy !== 1'b0 || period_start !== 1'b0) begin failures++; $display("FAIL reset_flags got busy=%b ps=%b exp 0 0", busy, period_start); end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (pwm_out !== 16'hFFFF) begin failures++; $display("FAIL reset_release_static got=%h exp=%h", pwm_out, 16'hFFFF); end
  endtask

  task automatic test_static();
    bit seen;
    do_reset();
    en_out = 16'h00FF;
    en_pwm = 16'h0000;
    duty   = 8'd64;
    checks++;
    if (pwm_out !== 16'h0000) begin failures++; $display("FAIL static_before got=%h exp=%h", pwm_out, 16'h0000); end
    pulse_cfg();
    checks++;
    if (pwm_out !== 16'h00FF) begin failures++; $display("FAIL static_out got=%h exp=%h", pwm_out, 16'h00FF); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL static_busy got=%b exp=0", busy); end
    seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      if (period_start || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL static_no_run got=%b exp=0", seen); end
    en_out = 16'h0F0F;
    step();
    checks++;
    if (pwm_out !== 16'h0F0F) begin failures++; $display("FAIL static_live_en got=%h exp=%h", pwm_out, 16'h0F0F); end
  endtask

  // Duty 25%, mid-period and boundary-coincident updates, and extremes.
  task automatic test_duty();
    int hi, first, last, ps;
    bit tmo;
    do_reset();
    en_out = 16'h0001;
    en_pwm = 16'h0001;
    duty   = 8'd64;
    pulse_cfg();
    checks++;
    if (busy !== 1'b1 || period_start !== 1'b1) begin failures++; $display("FAIL duty_entry got busy=%b ps=%b exp 1 1", busy, period_start); end

    measure(0, 8'd0, hi, first, last, ps, tmo);
    checks++;
    if (tmo || hi !== 640 || first !== 1 || last !== 640) begin failures++; $display("FAIL duty25_p1 got hi=%0d first=%0d last=%0d tmo=%b exp 640 1 640 0", hi, first, last, tmo); end
    checks++;
    if (ps !== 2560) begin failures++; $display("FAIL duty25_period got=%0d exp=2560", ps); end

    // write 192 mid-period: this period must still be 64
    measure(100, 8'd192, hi, first, last, ps, tmo);
    checks++;
    if (tmo || hi !== 640 || ps !== 2560) begin failures++; $display("FAIL midwrite_keep got hi=%0d ps=%0d tmo=%b exp 640 2560 0", hi, ps, tmo); end

    // 192 now active; write 64 coincident with the closing boundary
    measure(2559, 8'd64, hi, first, last, ps, tmo);
    checks++;
    if (tmo || hi !== 1920 || last !== 1920) begin failures++; $display("FAIL midwrite_next got hi=%0d last=%0d tmo=%b exp 1920 1920 0", hi, last, tmo); end

    measure(2559, 8'd192, hi, first, last, ps, tmo);
    checks++;
    if (tmo || hi !== 640) begin failures++; $display("FAIL coincident_64 got hi=%0d tmo=%b exp 640 0", hi, tmo); end

    measure(2559, 8'd0, hi, first, last, ps, tmo);
    checks++;
    if (tmo || hi !== 1920) begin failures++; $display("FAIL coincident_192 got hi=%0d tmo=%b exp 1920 0", hi, tmo); end

    measure(2559, 8'd255, hi, first, last, ps, tmo);
    checks++;
    if (tmo || hi !== 0) begin failures++; $display("FAIL duty0 got hi=%0d tmo=%b exp 0 0", hi, tmo); end

    measure(0, 8'd0, hi, first, last, ps, tmo);
    checks++;
    if (tmo || hi !== 2560 || ps !== 2560) begin failures++; $display("FAIL duty255 got hi=%0d ps=%0d tmo=%b exp 2560 2560 0", hi, ps, tmo); end
    step();
    checks++;
    if (pwm_out[0] !== 1'b1) begin failures++; $display("FAIL duty255_wrap got=%b exp=1", pwm_out[0]); end
  endtask

  task automatic test_stop();
    int n;
    bit seen;
    do_reset();
    en_out = 16'h0003;
    en_pwm = 16'h0001;
    duty   = 8'd128;
    pulse_cfg();
    for (int i = 0; i < 50; i++) step();
    en_pwm = 16'h0000;
    pulse_cfg();
    n = 0;
    while (busy && n < 3000) begin
      step();
      n++;
    end
    checks++;
    if (busy !== 1'b0 || n !== 2509) begin failures++; $display("FAIL stop_at_boundary got busy=%b steps=%0d exp 0 2509", busy, n); end
    checks++;
    if (pwm_out !== 16'h0002) begin failures++; $display("FAIL stop_last_level got=%h exp=%h", pwm_out, 16'h0002); end
    step();
    checks++;
    if (pwm_out !== 16'h0003) begin failures++; $display("FAIL stop_static got=%h exp=%h", pwm_out, 16'h0003); end
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (period_start || busy) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL stop_idle got=%b exp=0", seen); end
  endtask

  task automatic test_reset_mid();
    int hi, first, last, ps;
    bit tmo;
    do_reset();
    en_out = 16'h0001;
    en_pwm = 16'h0001;
    duty   = 8'd128;
    pulse_cfg();
    for (int i = 0; i < 1003; i++) step();
    checks++;
    if (pwm_out !== 16'h0001) begin failures++; $display("FAIL rstmid_pre got=%h exp=%h", pwm_out, 16'h0001); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (pwm_out !== 16'h0000 || busy !== 1'b0 || period_start !== 1'b0) begin failures++; $display("FAIL rstmid_async got pwm=%h busy=%b ps=%b exp 0000 0 0", pwm_out, busy, period_start); end
    step();
    step();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    checks++;
    if (pwm_out !== 16'h0001 || busy !== 1'b0) begin failures++; $display("FAIL rstmid_release got pwm=%h busy=%b exp 0001 0", pwm_out, busy); end
    pulse_cfg();
    measure(0, 8'd0, hi, first, last, ps, tmo);
    checks++;
    if (tmo || hi !== 1280 || ps !== 2560 || first !== 1) begin failures++; $display("FAIL rstmid_restart got hi=%0d ps=%0d first=%0d tmo=%b exp 1280 2560 1 0", hi, ps, first, tmo); end
  endtask

`ifdef PWM_RAMP_EN
  task automatic test_ramp();
    int n;
    do_reset();
    checks++;
    if (ramp_done !== 1'b1) begin failures++; $display("FAIL ramp_reset got=%b exp=1", ramp_done); end
    en_out = 16'h0001;
    en_pwm = 16'h0001;
    duty   = 8'd10;
    pulse_cfg();
    for (int i = 0; i < 5; i++) step();
    duty = 8'd14;
    pulse_cfg();
    checks++;
    if (ramp_done !== 1'b0) begin failures++; $display("FAIL ramp_start got=%b exp=0", ramp_done); end
    for (int k = 1; k <= 4; k++) begin
      step();
      n = 0;
      while (!period_start && n < 3000) begin
        step();
        n++;
      end
      checks++;
      if (!period_start || ramp_done !== (k == 4)) begin failures++; $display("FAIL ramp_boundary_%0d got done=%b ps=%b exp done=%b", k, ramp_done, period_start, (k == 4)); end
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_static();
    test_duty();
    test_stop();
    test_reset_mid();
`ifdef PWM_RAMP_EN
    test_ramp();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pwm_scheduler.md
Name: pwm_scheduler

Overview:
Consumes the SPI register-bank outputs (output enables, PWM selects, duty cycle) and drives 16 output pins. Runs a prescaled 8-bit PWM period counter. Shadows PWM configuration so that changes take effect only at period boundaries, which prevents glitched or truncated pulses. Sits between the SPI peripheral register bank and the top-level pin muxing.

Parameters:
CLK_DIV, 10, clk cycles per PWM counter tick; legal range 1..65535
CNT_W, 8, PWM counter width; the period is 2**CNT_W ticks

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en_out  input  16  per-channel output enable; live, not shadowed
en_pwm  input  16  per-channel PWM select; shadowed
duty  input  8  target duty cycle; shadowed
cfg_valid  input  1  single-cycle pulse, asserted when the register bank commits a write
pwm_out  output  16  registered channel outputs
period_start  output  1  single-cycle pulse on the tick where the counter is 0 (RUN state only)
busy  output  1  high while in RUN

Behaviour:
- Reset is asynchronous, active-low; the block is clocked on clk.
- Reset values: pwm_out=0, period_start=0, busy=0, state=IDLE, prescaler=0, cnt=0, shadow en_pwm=0, shadow duty=0, pending=0.
- Prescaler:
  - Counts 0..CLK_DIV-1 while in RUN.
  - tick is asserted when prescaler==CLK_DIV-1; prescaler then wraps to 0.
  - With CLK_DIV=1, tick is asserted every cycle.
- Counter: cnt increments on each tick and wraps from 255 to 0. boundary = tick && cnt==255.
- pending: set by cfg_valid; cleared whenever the shadow registers load.
- FSM:
  - IDLE: prescaler and cnt are held at 0; busy=0.
    - On cfg_valid with en_pwm!=0: load shadows from the inputs, go to RUN, cnt=0, prescaler=0.
  - RUN: busy=1.
    - On boundary with (pending || cfg_valid): load shadows from the current inputs.
    - If the loaded en_pwm==0: go to IDLE, cnt=0.
  - cfg_valid coincident with boundary uses that cycle's input values; no extra period of delay.
- PWM level, computed from shadow duty d:
  - d==0: always low.
  - d==255: always high.
  - otherwise: high when cnt<d.
- pwm_out[i] is registered with 1-cycle latency from en_out, the shadows and cnt:
  - en_out[i]==0: output 0.
  - en_out[i]==1 and shadow en_pwm[i]==0: output 1.
  - otherwise: output the PWM level.
- en_out changes are visible on pwm_out 1 cycle later, regardless of period position.
- In IDLE, any channel with en_out=1 outputs a static 1 (shadow en_pwm is 0).
- period_start: registered; high for 1 cycle after the tick that moves cnt to 0, and after RUN entry.
- Reset mid-period: all state returns to reset values immediately; pwm_out is 0 asynchronously.

Optional Feature:
Macro: PWM_RAMP_EN.
- Defined:
  - The shadow duty does not jump. At each boundary it steps by ±1 toward the latched target duty.
  - pending clears only when the shadow duty equals the target.
  - RUN→IDLE still occurs immediately when the loaded en_pwm==0.
  - Additional output ramp_done (1 bit, reset 1) is high when the shadow duty equals the target.
- Not defined: the shadow duty loads the target directly, and the ramp_done port is absent.

Decomposition:
- Shared package pwm_pkg:
  - state enum typedef {IDLE, RUN}
  - NUM_CH=16
  - DUTY_W=8
  - localparams DUTY_OFF=8'h00 and DUTY_FULL=8'hFF
- One sub-module, pwm_prescaler: counter with enable and synchronous clear, producing tick. It is reusable for other timed blocks.

Test Plan:
- Static outputs: reset, then en_out=16'h00FF, en_pwm=0, cfg_valid → pwm_out=16'h00FF 1 cycle later; busy=0; period_start never asserts.
- Duty 25%: CLK_DIV=10, en_out=en_pwm=16'h0001, duty=64, cfg_valid → busy=1; pwm_out[0] high for 640 clks, low for 1920 clks, repeating; period_start every 2560 clks.
- Boundary update: while running at duty=64, write duty=192 mid-period → the current period keeps 64; the next period is high for 1920 clks. Repeat with cfg_valid coincident with boundary → 192 applies immediately.
- Extremes: duty=0 → pwm_out[0] constant 0; duty=255 → constant 1 across the 255→0 wrap.
- Stop: cfg_valid with en_pwm=0 while running → at the next boundary the state goes to IDLE, busy=0, and enabled channels output a static 1.
- Reset mid-period: assert rst_n low at cnt=100 → pwm_out=0 immediately; after release, busy=0 and cnt=0.
- (PWM_RAMP_EN) Ramp: duty 10→14 → shadow duty reaches 14 after 4 boundaries; ramp_done goes high on the 4th boundary.
